// File: rtl/mod_down_timer_if.sv
// Handshake/control bundle for mod_down_timer.
// master drives i_* requests; slave (the timer) drives o_* status.
interface mod_down_timer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] i_load_val;
   logic             i_start;
   logic             i_mode;
   logic             i_enable;
   logic             i_abort;
   logic [WIDTH-1:0] o_count;
   logic             o_busy;
   logic             o_done;
   logic             o_err;
   logic [7:0]       o_periods;

   modport master (
      output i_load_val, i_start, i_mode, i_enable, i_abort,
      input  o_count, o_busy, o_done, o_err, o_periods
   );

   modport slave (
      input  i_load_val, i_start, i_mode, i_enable, i_abort,
      output o_count, o_busy, o_done, o_err, o_periods
   );
endinterface

// File: rtl/mod_down_timer.sv
// Loadable down-counting period timer, one-shot or auto-reload.
// Ports: clk, rst (sync, active-low), bus (mod_down_timer_if.slave):
//   i_load_val/i_start/i_mode latch a modulus N and start counting N-1..0;
//   i_enable pauses, i_abort cancels; o_count/o_busy/o_done/o_err/o_periods.
module mod_down_timer #(
   parameter int WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   mod_down_timer_if.slave bus
);
   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t           r_state;
   state_t           w_state;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_count;
   logic [WIDTH-1:0] r_n;
   logic [WIDTH-1:0] w_n;
   logic             r_mode;
   logic             w_mode;
   logic             r_done;
   logic             w_done;
   logic             r_err;
   logic             w_err;
   logic [7:0]       r_periods;
   logic [7:0]       w_periods;
   logic             w_start_ok;

   assign w_start_ok = bus.i_start && (bus.i_load_val != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_count   <= '0;
         r_n       <= '0;
         r_mode    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_periods <= 8'd0;
      end else begin
         r_state   <= w_state;
         r_count   <= w_count;
         r_n       <= w_n;
         r_mode    <= w_mode;
         r_done    <= w_done;
         r_err     <= w_err;
         r_periods <= w_periods;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_count   = r_count;
      w_n       = r_n;
      w_mode    = r_mode;
      w_done    = 1'b0;
      w_err     = 1'b0;
      w_periods = r_periods;
      if (bus.i_abort) begin
         w_state = S_IDLE;
         w_count = '0;
      end else if (w_start_ok) begin
         // Restart overrides any terminal count in the same cycle.
         w_n       = bus.i_load_val;
         w_mode    = bus.i_mode;
         w_count   = bus.i_load_val - WIDTH'(1);
         w_periods = 8'd0;
         w_state   = S_RUN;
      end else begin
         // A rejected start only flags err; counting carries on.
         w_err = bus.i_start;
         if (r_state == S_RUN && bus.i_enable) begin
            if (r_count != '0) begin
               w_count = r_count - WIDTH'(1);
            end else begin
               w_done = 1'b1;
               if (r_periods != 8'hFF)
                  w_periods = r_periods + 8'd1;
               if (r_mode) begin
                  w_count = r_n - WIDTH'(1);
               end else begin
                  w_state = S_IDLE;
                  w_count = '0;
               end
            end
         end
      end
   end

   assign bus.o_count   = r_count;
   assign bus.o_busy    = (r_state == S_RUN);
   assign bus.o_done    = r_done;
   assign bus.o_err     = r_err;
   assign bus.o_periods = r_periods;
endmodule

// File: tb/tb_mod_down_timer.sv
// Scoreboard bench for mod_down_timer: cycle model pushes expected
// outputs per driven cycle, popped and compared after the clock edge.
module tb_mod_down_timer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mod_down_timer_if #(.WIDTH(8)) u_if ();

   mod_down_timer #(.WIDTH(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   typedef struct {
      int unsigned cnt;
      bit          busy;
      bit          done;
      bit          err;
      int unsigned per;
   } exp_t;

   exp_t        sb[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   bit          m_run  = 0;
   int unsigned m_cnt  = 0;
   int unsigned m_n    = 0;
   bit          m_mode = 0;
   int unsigned m_per  = 0;

   task automatic chk(input string tag, input int unsigned obs,
                      input int unsigned exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
   endtask

   task automatic tick();
      exp_t e;
      e.done = 0;
      e.err  = 0;
      if (!rst) begin
         m_run = 0; m_cnt = 0; m_n = 0; m_mode = 0; m_per = 0;
      end else if (u_if.i_abort) begin
         m_run = 0; m_cnt = 0;
      end else if (u_if.i_start && u_if.i_load_val != 0) begin
         m_n    = u_if.i_load_val;
         m_mode = u_if.i_mode;
         m_cnt  = m_n - 1;
         m_per  = 0;
         m_run  = 1;
      end else begin
         e.err = u_if.i_start;
         if (m_run && u_if.i_enable) begin
            if (m_cnt > 0) m_cnt--;
            else begin
               e.done = 1;
               if (m_per < 255) m_per++;
               if (m_mode) m_cnt = m_n - 1;
               else m_run = 0;
            end
         end
      end
      e.cnt  = m_cnt;
      e.busy = m_run;
      e.per  = m_per;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("count", u_if.o_count, e.cnt);
      chk("busy", u_if.o_busy, e.busy);
      chk("done", u_if.o_done, e.done);
      chk("err", u_if.o_err, e.err);
      chk("periods", u_if.o_periods, e.per);
   endtask

   task automatic go(input int lv, input bit md);
      u_if.i_start    = 1;
      u_if.i_load_val = 8'(lv);
      u_if.i_mode     = md;
      tick();
      u_if.i_start = 0;
   endtask

   task automatic stop();
      u_if.i_abort = 1;
      tick();
      u_if.i_abort = 0;
   endtask

   initial begin
      int k;
      u_if.i_load_val = 0;
      u_if.i_start    = 0;
      u_if.i_mode     = 0;
      u_if.i_enable   = 1;
      u_if.i_abort    = 0;
      tick();
      tick();
      rst = 1;
      tick();

      // one-shot N=5
      go(5, 0);
      k = 1;
      while (!u_if.o_done && k < 20) begin tick(); k++; end
      chk("os_lat", k, 6);
      chk("os_busy", u_if.o_busy, 0);
      chk("os_per", u_if.o_periods, 1);
      tick();

      // auto-reload N=3, 10 periods
      go(3, 1);
      repeat (30) tick();
      chk("ar_per", u_if.o_periods, 10);
      chk("ar_cnt", u_if.o_count, 2);
      stop();

      // N=2 saturation
      go(2, 1);
      repeat (600) tick();
      chk("sat_per", u_if.o_periods, 255);
      stop();

      // N=1 auto: done every cycle
      go(1, 1);
      repeat (4) tick();
      chk("n1_done", u_if.o_done, 1);
      stop();

      // pause
      go(4, 0);
      tick();
      u_if.i_enable = 0;
      repeat (3) tick();
      chk("pz_hold", u_if.o_count, 2);
      u_if.i_enable = 1;
      k = 5;
      while (!u_if.o_done && k < 20) begin tick(); k++; end
      chk("pz_lat", k, 8);

      // restart at terminal count
      go(3, 1);
      repeat (2) tick();
      chk("rs_at0", u_if.o_count, 0);
      go(6, 0);
      chk("rs_done", u_if.o_done, 0);
      chk("rs_cnt", u_if.o_count, 5);
      chk("rs_per", u_if.o_periods, 0);

      // abort with start
      u_if.i_abort = 1;
      go(7, 1);
      u_if.i_abort = 0;
      chk("ab_busy", u_if.o_busy, 0);
      chk("ab_cnt", u_if.o_count, 0);
      tick();

      // zero modulus in IDLE then in RUN
      go(0, 1);
      chk("z0_err", u_if.o_err, 1);
      chk("z0_busy", u_if.o_busy, 0);
      tick();
      go(5, 0);
      tick();
      go(0, 1);
      chk("z1_err", u_if.o_err, 1);
      chk("z1_cnt", u_if.o_count, 2);
      repeat (4) tick();

      // reset mid-run
      go(3, 1);
      tick();
      rst = 0;
      tick();
      rst = 1;
      chk("rr_cnt", u_if.o_count, 0);
      chk("rr_busy", u_if.o_busy, 0);
      tick();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         u_if.i_start    = ($urandom_range(0, 15) == 0);
         u_if.i_load_val = 8'($urandom_range(0, 6));
         u_if.i_mode     = 1'($urandom_range(0, 1));
         u_if.i_enable   = ($urandom_range(0, 3) != 0);
         u_if.i_abort    = ($urandom_range(0, 40) == 0);
         rst             = ($urandom_range(0, 100) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mod_down_timer.md
# mod_down_timer

Loadable down-counting period timer: the countdown counterpart to the team's free-running modulo-N up-counter. It latches a modulus N on a start pulse and counts N-1 down to 0. On each terminal count it either stops (one-shot) or reloads (auto-reload). It sits beside the up-counter in the timing/sequencing fabric and supplies programmable delays and periodic ticks with busy/done handshaking.

## Interface
- WIDTH, default 8: width of modulus and count.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-low.
- load_val  input  WIDTH  modulus N, sampled only on an accepted start.
- start  input  1  start/restart request, sampled every cycle.
- mode  input  1  0 = one-shot, 1 = auto-reload; sampled only on an accepted start.
- enable  input  1  count enable; low pauses the count in RUN.
- abort  input  1  cancel; returns to IDLE.
- count  output  WIDTH  current count value.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse per completed period.
- err  output  1  one-cycle pulse when start is rejected (load_val == 0).
- periods  output  8  completed periods since last accepted start, saturates at 255.

## Operation
- States:
  - IDLE: busy=0, count=0.
  - RUN: busy=1.
- Internal latches: N_reg (WIDTH bits) and mode_reg, written only on an accepted start.
- Per-cycle priority, highest first: reset, abort, start, count.
- Abort, any state:
  - Go to IDLE; count=0.
  - No done pulse; periods holds its value.
- Start with load_val != 0, any state:
  - N_reg=load_val, mode_reg=mode.
  - count=load_val-1, periods=0, go to RUN.
  - A start in RUN is a restart. It suppresses any terminal count in that same cycle.
- Start with load_val == 0:
  - Rejected: err pulses next cycle.
  - State, count, N_reg, mode_reg and periods are unchanged.
- RUN, enable=1, count != 0: count decrements by 1.
- RUN, enable=1, count == 0 (terminal count):
  - done pulses next cycle; periods increments, saturating at 255.
  - mode_reg=0: go to IDLE, count stays 0.
  - mode_reg=1: count=N_reg-1, stay in RUN.
- RUN, enable=0: count, state and periods hold; no done.
- enable is ignored in IDLE.
- N=1, auto-reload: count stays 0 and done pulses on every enabled cycle.
- Arithmetic: N_reg-1 is computed in WIDTH bits; N_reg is never 0 in RUN. No count path ever wraps below 0.

## Timing
- All outputs are registered.
- Reset values: count=0, busy=0, done=0, err=0, periods=0, state IDLE, N_reg=0, mode_reg=0.
- Reset mid-operation: next cycle all values are at reset, with no done or err pulse.
- Start accepted at cycle t: at t+1, busy=1 and count=N-1. enable at cycle t has no effect.
- One-shot, enable held high, start at cycle t:
  - count takes N-1 at t+1 through 0 at t+N.
  - done=1 and busy=0 at t+N+1.
  - Total latency from start to done is N+1 cycles.
- Auto-reload, enable held high:
  - done pulses every N cycles, first at t+N+1.
  - count=N-1 in the same cycle as each done.
- Each cycle enable is low extends the period by exactly one cycle.
- Abort at cycle k: busy=0 and count=0 at k+1; a done that would have fired at k+1 is suppressed.
- err is high for exactly one cycle, at t+1 after the rejected start.
- done and err are never high for two consecutive cycles, except the N=1 auto-reload case for done.

## Test plan
- One-shot: reset, then start with load_val=5, mode=0, enable=1 -> count 4,3,2,1,0; done=1 and busy=0 on the 6th cycle after start; periods=1.
- Auto-reload: load_val=3, mode=1, enable=1, 10 periods -> done every 3 cycles; count sequence 2,1,0 repeats; periods=10. Separately, run N=2 for 300 periods -> periods saturates at 255.
- Pause: load_val=4, mode=0, enable low for 3 cycles while count=2 -> count holds at 2; done arrives 3 cycles later than unpaused (cycle 8 after start).
- Restart and abort:
  - start with load_val=6 in the same cycle count==0 during RUN -> no done; count=5; periods=0.
  - abort asserted together with start -> IDLE next cycle, count=0, no done.
- Zero modulus: start with load_val=0, first while IDLE, then while RUN at count=3 -> err pulses once each time; state and count unaffected (RUN continues 2,1,0).
- Reset mid-RUN: rst low while auto-reload is running at count=1 -> next cycle count=0, busy=0, periods=0, no done.
